// File: rtl/lvds_frame_scan.sv
// LVDS panel raster timing with image-window fetch from a 1-clock-latency RAM.
// Pixel, de, syncs and frame_start share a 3-clock latency from the counters.
module lvds_frame_scan #(
    parameter int unsigned H_ACTIVE = 1024,
    parameter int unsigned H_FP     = 24,
    parameter int unsigned H_SYNC   = 136,
    parameter int unsigned H_BP     = 160,
    parameter int unsigned V_ACTIVE = 768,
    parameter int unsigned V_FP     = 3,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 29,
    parameter int unsigned IMG_W    = 200,
    parameter int unsigned IMG_H    = 200,
    parameter int unsigned X0       = 412,
    parameter int unsigned Y0       = 284,
    parameter logic [17:0] BORDER   = 18'h00000
) (
    input  logic        clkq,
    input  logic        rst_n,
    output logic [15:0] addrX,
    output logic [1:0]  en,
    input  logic [5:0]  d_inR,
    input  logic [5:0]  d_inG,
    input  logic [5:0]  d_inB,
    output logic [5:0]  pix_r,
    output logic [5:0]  pix_g,
    output logic [5:0]  pix_b,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned CTL_W   = 5;
    localparam int unsigned C_VIS   = 4;
    localparam int unsigned C_HS    = 3;
    localparam int unsigned C_VS    = 2;
    localparam int unsigned C_WIN   = 1;
    localparam int unsigned C_FS    = 0;

    // Window must lie inside the active area and fit the 16-bit address space.
    if (X0 + IMG_W > H_ACTIVE || Y0 + IMG_H > V_ACTIVE) begin : g_bad_window
        $error("lvds_frame_scan: image window extends outside the active area");
    end
    if (IMG_W * IMG_H > 65536) begin : g_bad_size
        $error("lvds_frame_scan: image larger than the 16-bit address space");
    end

    logic [HW-1:0]    h_cnt_q, h_cnt_d;
    logic [VW-1:0]    v_cnt_q, v_cnt_d;
    logic [15:0]      ptr_q, ptr_d;
    logic [15:0]      addr_q, addr_d;
    logic [1:0]       en_q, en_d;
    logic [CTL_W-1:0] ctl1_q, ctl1_d, ctl2_q;
    logic [17:0]      pix_q, pix_d;
    logic             de_q, hsync_q, vsync_q, fs_q;

    logic h_wrap_c, v_wrap_c, vis_c, hs_c, vs_c, win_c, fs_c;

    // Stage 0: raster counters, decode and incremental window address.
    always_comb begin
        h_wrap_c = (h_cnt_q == HW'(H_TOTAL - 1));
        v_wrap_c = (v_cnt_q == VW'(V_TOTAL - 1));

        h_cnt_d = h_wrap_c ? '0 : h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_wrap_c) begin
            v_cnt_d = v_wrap_c ? '0 : v_cnt_q + VW'(1);
        end

        vis_c = (h_cnt_q < HW'(H_ACTIVE)) && (v_cnt_q < VW'(V_ACTIVE));
        hs_c  = (h_cnt_q >= HW'(H_ACTIVE + H_FP)) &&
                (h_cnt_q <  HW'(H_ACTIVE + H_FP + H_SYNC));
        vs_c  = (v_cnt_q >= VW'(V_ACTIVE + V_FP)) &&
                (v_cnt_q <  VW'(V_ACTIVE + V_FP + V_SYNC));
        win_c = (h_cnt_q >= HW'(X0)) && (h_cnt_q < HW'(X0 + IMG_W)) &&
                (v_cnt_q >= VW'(Y0)) && (v_cnt_q < VW'(Y0 + IMG_H));
        fs_c  = (h_cnt_q == '0) && (v_cnt_q == '0);

        // Clearing on entry to (0,0) wins over the increment.
        ptr_d = ptr_q;
        if (h_wrap_c && v_wrap_c) begin
            ptr_d = '0;
        end else if (win_c) begin
            ptr_d = ptr_q + 16'd1;
        end

        addr_d = win_c ? ptr_q : addr_q;
        en_d   = win_c ? 2'b01 : 2'b00;
        ctl1_d = {vis_c, hs_c, vs_c, win_c, fs_c};

        // Stage 3 pixel select: RAM data inside the window, border elsewhere in active.
        pix_d = '0;
        if (ctl2_q[C_WIN]) begin
            pix_d = {d_inR, d_inG, d_inB};
        end else if (ctl2_q[C_VIS]) begin
            pix_d = BORDER;
        end
    end

    always_ff @(posedge clkq or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
            en_q    <= 2'b00;
            ctl1_q  <= '0;
            ctl2_q  <= '0;
            pix_q   <= '0;
            de_q    <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            en_q    <= en_d;
            ctl1_q  <= ctl1_d;
            ctl2_q  <= ctl1_q;
            pix_q   <= pix_d;
            de_q    <= ctl2_q[C_VIS];
            hsync_q <= ~ctl2_q[C_HS];
            vsync_q <= ~ctl2_q[C_VS];
            fs_q    <= ctl2_q[C_FS];
        end
    end

    assign addrX       = addr_q;
    assign en          = en_q;
    assign pix_r       = pix_q[17:12];
    assign pix_g       = pix_q[11:6];
    assign pix_b       = pix_q[5:0];
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_lvds_frame_scan.sv
// Bench for lvds_frame_scan on a shrunk raster; outputs are predicted from the
// raster position (cycle index since reset release) and a 1-clock RAM model.
module tb_lvds_frame_scan;

    localparam int HA = 40, HF = 4, HS = 6, HB = 8;
    localparam int VA = 30, VF = 2, VS = 3, VB = 4;
    localparam int IW = 10, IH = 8, WX = 12, WY = 9;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;
    localparam logic [17:0] BRD = 18'h2A5C3;

    logic        clkq = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addrX;
    logic [1:0]  en;
    logic [5:0]  d_inR = '0, d_inG = '0, d_inB = '0;
    logic [5:0]  pix_r, pix_g, pix_b;
    logic        hsync, vsync, de, frame_start;

    int total = 0, bad = 0;
    int n = 0;
    int exp_addr = 0;
    bit agg = 0;
    int fs_first = -1, fs_second = -1;
    int fetch_cnt0 = 0, fetch_cnt1 = 0;
    int first_fetch_n = -1, first_fetch_a = -1, last_fetch_a0 = -1;
    int de_cnt = 0, hs_low = 0, vs_low = 0;

    lvds_frame_scan #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .IMG_W(IW), .IMG_H(IH), .X0(WX), .Y0(WY), .BORDER(BRD)
    ) dut (
        .clkq(clkq), .rst_n(rst_n), .addrX(addrX), .en(en),
        .d_inR(d_inR), .d_inG(d_inG), .d_inB(d_inB),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start)
    );

    always #5 clkq = ~clkq;

    // Image RAM: R=addr[5:0], G=addr[11:6], B={2'b0,addr[15:12]}, one clock latency.
    always @(posedge clkq) begin
        if (en == 2'b01) begin
            d_inR <= addrX[5:0];
            d_inG <= addrX[11:6];
            d_inB <= {2'b00, addrX[15:12]};
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    function automatic int hpos(int s); return s % HT; endfunction
    function automatic int vpos(int s); return (s / HT) % VT; endfunction

    function automatic bit in_win(int s);
        int h = hpos(s), v = vpos(s);
        return (h >= WX) && (h < WX + IW) && (v >= WY) && (v < WY + IH);
    endfunction

    function automatic int waddr(int s);
        return (vpos(s) - WY) * IW + (hpos(s) - WX);
    endfunction

    function automatic logic [17:0] ram_word(int a);
        logic [15:0] x = 16'(a);
        return {x[5:0], x[11:6], 2'b00, x[15:12]};
    endfunction

    task automatic reset_vals(input string tag);
        check_val({tag, "_de"}, 32'(de), 32'd0);
        check_val({tag, "_hsync"}, 32'(hsync), 32'd1);
        check_val({tag, "_vsync"}, 32'(vsync), 32'd1);
        check_val({tag, "_en"}, 32'(en), 32'd0);
        check_val({tag, "_addr"}, 32'(addrX), 32'd0);
        check_val({tag, "_fs"}, 32'(frame_start), 32'd0);
        check_val({tag, "_pix"}, 32'({pix_r, pix_g, pix_b}), 32'd0);
    endtask

    // One clock: predict from raster position n-1 (fetch side) and n-3 (outputs).
    task automatic run_one();
        int s1, s3, h, v;
        logic        e_de, e_hs, e_vs, e_fs;
        logic [17:0] e_pix;
        @(posedge clkq);
        n++;
        s1 = n - 1;
        if (in_win(s1)) exp_addr = waddr(s1);
        @(negedge clkq);
        check_val("en", 32'(en), in_win(s1) ? 32'd1 : 32'd0);
        check_val("addrX", 32'(addrX), 32'(exp_addr));
        s3 = n - 3;
        e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_pix = '0;
        if (s3 >= 0) begin
            h = hpos(s3);
            v = vpos(s3);
            e_de = (h < HA) && (v < VA);
            e_hs = !((h >= HA + HF) && (h < HA + HF + HS));
            e_vs = !((v >= VA + VF) && (v < VA + VF + VS));
            e_fs = (h == 0) && (v == 0);
            e_pix = in_win(s3) ? ram_word(waddr(s3)) : (e_de ? BRD : 18'd0);
        end
        check_val("de", 32'(de), 32'(e_de));
        check_val("hsync", 32'(hsync), 32'(e_hs));
        check_val("vsync", 32'(vsync), 32'(e_vs));
        check_val("frame_start", 32'(frame_start), 32'(e_fs));
        check_val("pix", 32'({pix_r, pix_g, pix_b}), 32'(e_pix));
        if (agg) begin
            if (frame_start) begin
                if (fs_first < 0) fs_first = n;
                else if (fs_second < 0) fs_second = n;
            end
            if (en == 2'b01) begin
                if (s1 / FR == 0) begin
                    fetch_cnt0++;
                    last_fetch_a0 = int'(addrX);
                    if (first_fetch_n < 0) begin
                        first_fetch_n = n;
                        first_fetch_a = int'(addrX);
                    end
                end else if (s1 / FR == 1) begin
                    fetch_cnt1++;
                end
            end
            if (n >= 3 && n < 3 + FR) begin
                if (de) de_cnt++;
                if (!hsync) hs_low++;
                if (!vsync) vs_low++;
            end
        end
    endtask

    // Asynchronous reset between edges, held for len clocks, released off-edge.
    task automatic do_reset(input int target, input int len);
        while (n < target) run_one();
        #2 rst_n = 1'b0;
        #1 reset_vals("async_rst");
        repeat (len) @(posedge clkq);
        @(negedge clkq);
        reset_vals("held_rst");
        rst_n = 1'b1;
        n = 0;
        exp_addr = 0;
    endtask

    initial begin
        int tgt;
        rst_n = 1'b0;
        repeat (5) @(posedge clkq);
        @(negedge clkq);
        reset_vals("por");
        rst_n = 1'b1;
        n = 0;
        exp_addr = 0;

        agg = 1'b1;
        repeat (2 * FR + 20) run_one();
        agg = 1'b0;
        check_val("fs_first_n", 32'(fs_first), 32'd3);
        check_val("frame_period", 32'(fs_second - fs_first), 32'(FR));
        check_val("fetches_f0", 32'(fetch_cnt0), 32'(IW * IH));
        check_val("fetches_f1", 32'(fetch_cnt1), 32'(IW * IH));
        check_val("first_fetch_n", 32'(first_fetch_n), 32'(WY * HT + WX + 1));
        check_val("first_fetch_addr", 32'(first_fetch_a), 32'd0);
        check_val("last_fetch_addr", 32'(last_fetch_a0), 32'(IW * IH - 1));
        check_val("de_per_frame", 32'(de_cnt), 32'(HA * VA));
        check_val("hs_low_per_frame", 32'(hs_low), 32'(HS * VT));
        check_val("vs_low_per_frame", 32'(vs_low), 32'(VS * HT));

        // Mid-frame reset inside the window (line WY+1, column WX+3).
        tgt = n + (((WY + 1) * HT + WX + 3) - (n % FR) + FR) % FR;
        do_reset(tgt, 3);
        repeat (FR + 50) run_one();

        for (int i = 0; i < 3; i++) begin
            do_reset(n + int'($urandom_range(1, FR)), int'($urandom_range(1, 4)));
        end
        repeat (FR + 10) run_one();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
